// File: rtl/ibex_compressed_encoder.sv
// ibex_compressed_encoder: RV32I->RV32C compressor and 16/32-bit parcel packer; define ENC_BRANCH_EN to also compress beq/bne/jal
module ibex_compressed_encoder #(
  parameter logic [15:0] OUT_NOP = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_word_o,
  output logic        hold_valid_o,
  output logic        last_compressed_o
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic small_imm, m_li, m_addi, m_mv, m_add, m_jr, m_jalr, m_lw, m_sw, m_ebreak, m_br, m_j;
  logic [15:0] c_br, c_j, cmp, hold;
  logic is_c, free, accept;
  assign opc = in_instr_i[6:0];
  assign rd  = in_instr_i[11:7];
  assign f3  = in_instr_i[14:12];
  assign rs1 = in_instr_i[19:15];
  assign rs2 = in_instr_i[24:20];
  assign f7  = in_instr_i[31:25];
  assign small_imm = in_instr_i[31:25] == {7{in_instr_i[25]}};
  assign m_li     = opc == 7'h13 && f3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && small_imm;
  assign m_addi   = opc == 7'h13 && f3 == 3'b000 && rs1 == rd && rd != 5'd0 && small_imm && in_instr_i[31:20] != 12'd0;
  assign m_mv     = opc == 7'h33 && f3 == 3'b000 && f7 == 7'd0 && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0;
  assign m_add    = opc == 7'h33 && f3 == 3'b000 && f7 == 7'd0 && rs1 == rd && rd != 5'd0 && rs2 != 5'd0;
  assign m_jr     = opc == 7'h67 && f3 == 3'b000 && in_instr_i[31:20] == 12'd0 && rd == 5'd0 && rs1 != 5'd0;
  assign m_jalr   = opc == 7'h67 && f3 == 3'b000 && in_instr_i[31:20] == 12'd0 && rd == 5'd1 && rs1 != 5'd0;
  assign m_lw     = opc == 7'h03 && f3 == 3'b010 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                    in_instr_i[31:27] == 5'd0 && in_instr_i[21:20] == 2'd0;
  assign m_sw     = opc == 7'h23 && f3 == 3'b010 && rs1[4:3] == 2'b01 && rs2[4:3] == 2'b01 &&
                    in_instr_i[31:27] == 5'd0 && in_instr_i[8:7] == 2'd0;
  assign m_ebreak = in_instr_i == 32'h0010_0073;
`ifdef ENC_BRANCH_EN
  logic [12:1] boff;
  logic [20:1] joff;
  assign boff = {in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8]};
  assign joff = {in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21]};
  assign m_br = opc == 7'h63 && f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1[4:3] == 2'b01 && boff[12:8] == {5{boff[8]}};
  assign m_j  = opc == 7'h6f && rd[4:1] == 4'd0 && joff[20:11] == {10{joff[11]}};
  assign c_br = {2'b11, f3[0], boff[8], boff[4:3], rs1[2:0], boff[7:6], boff[2:1], boff[5], 2'b01};
  assign c_j  = {~rd[0], 2'b01, joff[11], joff[4], joff[9:8], joff[10], joff[6], joff[7], joff[3:1], joff[5], 2'b01};
`else
  assign m_br = 1'b0;
  assign m_j  = 1'b0;
  assign c_br = 16'h0000;
  assign c_j  = 16'h0000;
`endif
  assign cmp = m_li     ? {3'b010, in_instr_i[25], rd, in_instr_i[24:20], 2'b01} :
               m_addi   ? {3'b000, in_instr_i[25], rd, in_instr_i[24:20], 2'b01} :
               m_mv     ? {4'b1000, rd, rs2, 2'b10} :
               m_add    ? {4'b1001, rd, rs2, 2'b10} :
               m_jr     ? {4'b1000, rs1, 5'd0, 2'b10} :
               m_jalr   ? {4'b1001, rs1, 5'd0, 2'b10} :
               m_lw     ? {3'b010, in_instr_i[25:23], rs1[2:0], in_instr_i[22], in_instr_i[26], rd[2:0], 2'b00} :
               m_sw     ? {3'b110, in_instr_i[25], in_instr_i[11:10], rs1[2:0], in_instr_i[9], in_instr_i[26], rs2[2:0], 2'b00} :
               m_ebreak ? 16'h9002 :
               m_br     ? c_br :
               m_j      ? c_j : 16'h0000;
  assign is_c = m_li | m_addi | m_mv | m_add | m_jr | m_jalr | m_lw | m_sw | m_ebreak | m_br | m_j;
  assign free       = !out_valid_o | out_ready_i;
  assign in_ready_o = free & !(flush_i & hold_valid_o);
  assign accept     = in_valid_i & in_ready_o;
  // pack parcels into words, flush beats input, output slot frees when drained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o       <= 1'b0;
      out_word_o        <= 32'd0;
      hold_valid_o      <= 1'b0;
      hold              <= 16'd0;
      last_compressed_o <= 1'b0;
    end else begin
      if (free) out_valid_o <= 1'b0;
      if (flush_i && hold_valid_o && free) begin
        out_word_o   <= {OUT_NOP, hold};
        out_valid_o  <= 1'b1;
        hold_valid_o <= 1'b0;
        hold         <= 16'd0;
      end else if (accept) begin
        last_compressed_o <= is_c;
        if (!hold_valid_o && is_c) begin
          hold         <= cmp;
          hold_valid_o <= 1'b1;
        end else if (!hold_valid_o) begin
          out_word_o  <= in_instr_i;
          out_valid_o <= 1'b1;
        end else if (is_c) begin
          out_word_o   <= {cmp, hold};
          out_valid_o  <= 1'b1;
          hold_valid_o <= 1'b0;
          hold         <= 16'd0;
        end else begin
          out_word_o  <= {in_instr_i[15:0], hold};
          out_valid_o <= 1'b1;
          hold        <= in_instr_i[31:16];
        end
      end
    end
  end
endmodule

// File: tb/tb_ibex_compressed_encoder.sv
// tb_ibex_compressed_encoder: scoreboard bench for the RV32C encoder/packer
module tb_ibex_compressed_encoder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b1;
  logic [31:0] in_instr_i = 32'd0;
  logic in_ready_o, out_valid_o, hold_valid_o, last_compressed_o;
  logic [31:0] out_word_o;
  int total = 0, bad = 0;
  logic [15:0] hq[$];
  logic [31:0] eq[$];
`ifdef ENC_BRANCH_EN
  localparam logic BR = 1'b1;
`else
  localparam logic BR = 1'b0;
`endif
  localparam int N = 19;
  logic [31:0] t_ins [N] = '{32'hFFF00293, 32'h00140413, 32'h00B00533, 32'h00B50533, 32'h00008067,
                             32'h000280E7, 32'h07C52483, 32'h08052483, 32'h00952423, 32'h01052423,
                             32'h00100073, 32'h00040413, 32'h02040413, 32'h00000013, 32'h00040863,
                             32'hFFDFF06F, 32'h10041063, 32'hF00410E3, 32'h01F00293};
  logic [16:0] t_exp [N] = '{{1'b1, 16'h52FD}, {1'b1, 16'h0405}, {1'b1, 16'h852E}, {1'b1, 16'h952E},
                             {1'b1, 16'h8082}, {1'b1, 16'h9282}, {1'b1, 16'h5D64}, 17'd0,
                             {1'b1, 16'hC504}, 17'd0, {1'b1, 16'h9002}, 17'd0, 17'd0, 17'd0,
                             {BR, 16'hC801}, {BR, 16'hBFF5}, 17'd0, {BR, 16'hF001}, {1'b1, 16'h42FD}};

  ibex_compressed_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_word_o(out_word_o),
    .hold_valid_o(hold_valid_o), .last_compressed_o(last_compressed_o)
  );

  always #5 clk = ~clk;

  function automatic void push_half(input logic [15:0] h);
    hq.push_back(h);
    if (hq.size() == 2) begin
      eq.push_back({hq[1], hq[0]});
      hq.delete();
    end
  endfunction

  // scoreboard: every transferred word must be the oldest expected word
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      total++;
      if (eq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word got=%h want=none", out_word_o);
      end else begin
        logic [31:0] w;
        w = eq.pop_front();
        if (out_word_o !== w) begin
          bad++;
          $display("FAIL word got=%h want=%h", out_word_o, w);
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [16:0] ex, output int waits);
    in_valid_i = 1'b1;
    in_instr_i = ins;
    waits = 0;
    @(negedge clk);
    while (!in_ready_o && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    total++;
    if (waits >= 40) begin
      bad++;
      $display("FAIL accept_timeout instr=%h", ins);
      return;
    end
    if (ex[16]) push_half(ex[15:0]);
    else begin
      push_half(ins[15:0]);
      push_half(ins[31:16]);
    end
    if (hold_valid_o !== (hq.size() == 1) || last_compressed_o !== ex[16]) begin
      bad++;
      $display("FAIL accept_state instr=%h got hold=%b lc=%b want hold=%b lc=%b",
               ins, hold_valid_o, last_compressed_o, hq.size() == 1, ex[16]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00000013;
    @(negedge clk);
    total++;
    if (in_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%b want=0", in_ready_o);
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    if (hq.size() == 1) push_half(16'h0001);
    total++;
    if (hold_valid_o !== 1'b0 || out_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_state got hold=%b ov=%b want hold=0 ov=1", hold_valid_o, out_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++;
    if (out_valid_o !== 1'b0 || out_word_o !== 32'd0 || hold_valid_o !== 1'b0 ||
        last_compressed_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset ov=%b w=%h hv=%b lc=%b rdy=%b want 0 0 0 0 1",
               out_valid_o, out_word_o, hold_valid_o, last_compressed_o, in_ready_o);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_pair();
    int w;
    send(32'h00140413, {1'b1, 16'h0405}, w);
    send(32'h00B50533, {1'b1, 16'h952E}, w);
    total++;
    if (out_valid_o !== 1'b1 || out_word_o !== 32'h952E0405) begin
      bad++;
      $display("FAIL pair_word got ov=%b w=%h want ov=1 w=952e0405", out_valid_o, out_word_o);
    end
    send(32'h123452B7, 17'd0, w);
    total++;
    if (out_word_o !== 32'h123452B7) begin
      bad++;
      $display("FAIL lui_word got=%h want=123452b7", out_word_o);
    end
    idle(2);
  endtask

  task automatic test_flush();
    int w;
    send(32'h00140413, {1'b1, 16'h0405}, w);
    send(32'h123452B7, 17'd0, w);
    total++;
    if (out_word_o !== 32'h52B70405 || hold_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL split_word got w=%h hv=%b want w=52b70405 hv=1", out_word_o, hold_valid_o);
    end
    do_flush();
    total++;
    if (out_word_o !== 32'h00011234) begin
      bad++;
      $display("FAIL flush_word got=%h want=00011234", out_word_o);
    end
    idle(1);
    flush_i = 1'b1;
    send(32'h123452B7, 17'd0, w);
    flush_i = 1'b0;
    total++;
    if (w != 0 || out_word_o !== 32'h123452B7) begin
      bad++;
      $display("FAIL empty_flush got waits=%0d w=%h want 0 123452b7", w, out_word_o);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int w, stalls;
    stalls = 0;
    for (int i = 0; i < N; i++) begin
      send(t_ins[i], t_exp[i], w);
      stalls += w;
    end
    total++;
    if (stalls != 0) begin
      bad++;
      $display("FAIL throughput stalls=%0d want=0", stalls);
    end
    if (hq.size() == 1) do_flush();
    idle(2);
  endtask

  task automatic test_backpressure();
    int w;
    logic [31:0] held;
    out_ready_i = 1'b0;
    send(32'h123452B7, 17'd0, w);
    held = out_word_o;
    in_valid_i = 1'b1;
    in_instr_i = 32'hFFF00293;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid_o !== 1'b1 || out_word_o !== held || in_ready_o !== 1'b0 || hold_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d got ov=%b w=%h rdy=%b hv=%b want 1 %h 0 0",
                 i, out_valid_o, out_word_o, in_ready_o, hold_valid_o, held);
      end
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    send(32'hFFF00293, {1'b1, 16'h52FD}, w);
    send(32'h00B00533, {1'b1, 16'h852E}, w);
    send(32'h08052483, 17'd0, w);
    idle(3);
    total++;
    if (eq.size() != 0 || hq.size() != 0) begin
      bad++;
      $display("FAIL bp_drain got eq=%0d hq=%0d want 0 0", eq.size(), hq.size());
    end
  endtask

  task automatic test_mid_reset();
    int w;
    send(32'h00140413, {1'b1, 16'h0405}, w);
    out_ready_i = 1'b0;
    send(32'h123452B7, 17'd0, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    eq.delete();
    hq.delete();
    total++;
    if (hold_valid_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got hv=%b ov=%b want 0 0", hold_valid_o, out_valid_o);
    end
    out_ready_i = 1'b1;
    send(32'h123452B7, 17'd0, w);
    total++;
    if (out_word_o !== 32'h123452B7) begin
      bad++;
      $display("FAIL post_reset got=%h want=123452b7", out_word_o);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_pair();
    test_flush();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL final_drain got=%0d want=0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
